// File: rtl/video_burst_reader_if.sv
// video_burst_reader_if: Avalon-MM burst-read request/return and Avalon-ST pixel
// signals of video_burst_reader, seen from the reader (master) or its peers (slave).
interface video_burst_reader_if #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int BURST_W = 9
);
    logic [ADDR_W-1:0]  m_address;
    logic               m_read;
    logic [BURST_W-1:0] m_burstcount;
    logic               m_waitrequest;
    logic [DATA_W-1:0]  m_readdata;
    logic               m_readdatavalid;
    logic [DATA_W-1:0]  st_data;
    logic               st_valid;
    logic               st_ready;
    logic               st_sop;
    logic               st_eop;

    modport master (
        output m_address, m_read, m_burstcount, st_data, st_valid, st_sop, st_eop,
        input  m_waitrequest, m_readdata, m_readdatavalid, st_ready
    );
    modport slave (
        input  m_address, m_read, m_burstcount, st_data, st_valid, st_sop, st_eop,
        output m_waitrequest, m_readdata, m_readdatavalid, st_ready
    );
endinterface

// File: rtl/video_burst_reader.sv
// video_burst_reader: credit-flow-controlled Avalon-MM burst reader streaming a linear
// SDRAM region to Avalon-ST with sop/eop; define BURST_4K_GUARD_EN to keep bursts inside 4 KiB pages.
module video_burst_reader #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int BURST_W    = 9,
    parameter int MAX_BURST  = 64,
    parameter int FIFO_DEPTH = 256,
    parameter int LEN_W      = 24
) (
    input  logic                clk_clk,
    input  logic                reset_reset,
    input  logic                ctrl_start,
    input  logic [ADDR_W-1:0]   ctrl_base,
    input  logic [LEN_W-1:0]    ctrl_words,
    output logic                ctrl_busy,
    output logic                ctrl_done,
    video_burst_reader_if.master bus
);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam int BSH = $clog2(DATA_W / 8);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t             state;
    logic [ADDR_W-1:0]  addr;
    logic [LEN_W-1:0]   remaining;
    logic [LEN_W-1:0]   total;
    logic [LEN_W-1:0]   pop_cnt;
    logic               sop_pending;
    logic [CW-1:0]      outstanding;
    logic [CW-1:0]      fifo_count;
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [DATA_W-1:0]  mem [FIFO_DEPTH];
    logic [BURST_W-1:0] len_max;
    logic [BURST_W-1:0] len;
    logic [31:0]        used;
    logic               accept;
    logic               load;
    logic               pop;
    logic               last_pop;

    assign len_max = (remaining < LEN_W'(MAX_BURST)) ? BURST_W'(remaining) : BURST_W'(MAX_BURST);
`ifdef BURST_4K_GUARD_EN
    logic [12:0] room;
    assign room = (13'h1000 - {1'b0, addr[11:0]}) >> BSH;
    assign len  = (32'(room) < 32'(len_max)) ? BURST_W'(room) : len_max;
`else
    assign len  = len_max;
`endif

    // A request still on the bus already owns its credits, so it is counted as used.
    assign used     = 32'(fifo_count) + 32'(outstanding) + (bus.m_read ? 32'(bus.m_burstcount) : 32'd0);
    assign accept   = bus.m_read && !bus.m_waitrequest;
    assign load     = (state == ISSUE) && (remaining != '0) && (!bus.m_read || accept)
                      && (used + 32'(len) <= 32'(FIFO_DEPTH));
    assign pop      = bus.st_valid && bus.st_ready;
    assign last_pop = pop && (pop_cnt == total - LEN_W'(1));

    assign bus.st_valid = fifo_count != '0;
    assign bus.st_data  = mem[rd_ptr];
    assign bus.st_sop   = bus.st_valid && sop_pending;
    assign bus.st_eop   = bus.st_valid && (pop_cnt == total - LEN_W'(1));

    always_ff @(posedge clk_clk) begin
        if (bus.m_readdatavalid) mem[wr_ptr] <= bus.m_readdata;
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            wr_ptr     <= wr_ptr + AW'(bus.m_readdatavalid);
            rd_ptr     <= rd_ptr + AW'(pop);
            fifo_count <= fifo_count + CW'(bus.m_readdatavalid) - CW'(pop);
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state            <= IDLE;
            addr             <= '0;
            remaining        <= '0;
            total            <= '0;
            pop_cnt          <= '0;
            sop_pending      <= 1'b0;
            outstanding      <= '0;
            bus.m_read       <= 1'b0;
            bus.m_address    <= '0;
            bus.m_burstcount <= '0;
            ctrl_busy        <= 1'b0;
            ctrl_done        <= 1'b0;
        end else begin
            ctrl_done   <= 1'b0;
            outstanding <= outstanding + (accept ? CW'(bus.m_burstcount) : CW'(0)) - CW'(bus.m_readdatavalid);
            if (pop) begin
                pop_cnt     <= pop_cnt + LEN_W'(1);
                sop_pending <= 1'b0;
            end
            case (state)
                IDLE: if (ctrl_start) begin
                    addr        <= ctrl_base;
                    remaining   <= ctrl_words;
                    total       <= ctrl_words;
                    pop_cnt     <= '0;
                    sop_pending <= 1'b1;
                    state       <= (ctrl_words == '0) ? DONE : ISSUE;
                    ctrl_busy   <= ctrl_words != '0;
                    ctrl_done   <= ctrl_words == '0;
                end
                ISSUE: begin
                    // Address and remaining advance when a burst is loaded; it is then held until accepted.
                    if (load) begin
                        bus.m_read       <= 1'b1;
                        bus.m_address    <= addr;
                        bus.m_burstcount <= len;
                        addr             <= addr + (ADDR_W'(len) << BSH);
                        remaining        <= remaining - LEN_W'(len);
                    end else if (accept) begin
                        bus.m_read <= 1'b0;
                    end
                    if (accept && remaining == '0) state <= DRAIN;
                end
                DRAIN: if (last_pop && outstanding == '0) begin
                    state     <= DONE;
                    ctrl_done <= 1'b1;
                    ctrl_busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_video_burst_reader.sv
// tb_video_burst_reader: directed bench for video_burst_reader with an Avalon-MM slave
// model (programmable waitrequest) and stream/burst monitors.
module tb_video_burst_reader;
    localparam int DATA_W = 32, ADDR_W = 32, BURST_W = 9, MAX_BURST = 64, FIFO_DEPTH = 256, LEN_W = 24;

    logic              clk_clk = 1'b0;
    logic              reset_reset = 1'b1;
    logic              ctrl_start = 1'b0;
    logic [ADDR_W-1:0] ctrl_base = '0;
    logic [LEN_W-1:0]  ctrl_words = '0;
    logic              ctrl_busy;
    logic              ctrl_done;

    int n_tests = 0;
    int n_fail = 0;

    always #5 clk_clk = ~clk_clk;

    video_burst_reader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_W(BURST_W)) bus ();

    video_burst_reader #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_W(BURST_W),
        .MAX_BURST(MAX_BURST), .FIFO_DEPTH(FIFO_DEPTH), .LEN_W(LEN_W)
    ) dut (
        .clk_clk(clk_clk),
        .reset_reset(reset_reset),
        .ctrl_start(ctrl_start),
        .ctrl_base(ctrl_base),
        .ctrl_words(ctrl_words),
        .ctrl_busy(ctrl_busy),
        .ctrl_done(ctrl_done),
        .bus(bus)
    );

    function automatic logic [31:0] pat(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // Slave: stalls each request for stall_n cycles, returns one word per cycle.
    int          stall_n = 0;
    int          stall_cnt = 0;
    logic [31:0] rq[$];
    assign bus.m_waitrequest = bus.m_read && (stall_cnt < stall_n);

    always @(posedge clk_clk) begin
        if (reset_reset) begin
            rq.delete();
            stall_cnt <= 0;
            bus.m_readdatavalid <= 1'b0;
            bus.m_readdata <= '0;
        end else begin
            if (rq.size() > 0) begin
                bus.m_readdatavalid <= 1'b1;
                bus.m_readdata <= pat(rq.pop_front());
            end else begin
                bus.m_readdatavalid <= 1'b0;
            end
            if (bus.m_read && bus.m_waitrequest) stall_cnt <= stall_cnt + 1;
            if (bus.m_read && !bus.m_waitrequest) begin
                stall_cnt <= 0;
                for (int i = 0; i < int'(bus.m_burstcount); i++) rq.push_back(bus.m_address + 32'(i * 4));
            end
        end
    end

    logic [31:0]        b_addr[$];
    int                 b_len[$];
    logic [31:0]        s_data[$];
    logic               s_sop[$];
    logic               s_eop[$];
    int                 done_cnt, hold_err, stall_cyc, acc_words, pop_words, max_used;
    logic               prev_stall = 1'b0;
    logic [31:0]        prev_addr;
    logic [BURST_W-1:0] prev_bc;
    logic               busy_after_start;

    always @(negedge clk_clk) begin
        if (reset_reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (bus.m_read !== 1'b1 || bus.m_address !== prev_addr || bus.m_burstcount !== prev_bc))
                hold_err++;
            prev_stall = bus.m_read && bus.m_waitrequest;
            prev_addr = bus.m_address;
            prev_bc = bus.m_burstcount;
            if (bus.m_read && bus.m_waitrequest) stall_cyc++;
            if (bus.m_read && !bus.m_waitrequest) begin
                b_addr.push_back(bus.m_address);
                b_len.push_back(int'(bus.m_burstcount));
                acc_words += int'(bus.m_burstcount);
            end
            if (bus.st_valid && bus.st_ready) begin
                s_data.push_back(bus.st_data);
                s_sop.push_back(bus.st_sop);
                s_eop.push_back(bus.st_eop);
                pop_words++;
            end
            if (acc_words - pop_words > max_used) max_used = acc_words - pop_words;
            if (ctrl_done) done_cnt++;
        end
    end

    function automatic void clear_mon();
        b_addr.delete(); b_len.delete(); s_data.delete(); s_sop.delete(); s_eop.delete();
        done_cnt = 0; hold_err = 0; stall_cyc = 0; acc_words = 0; pop_words = 0; max_used = 0;
    endfunction

    function automatic int stream_errs(input logic [31:0] base, input int n);
        int e = 0;
        for (int i = 0; i < s_data.size(); i++) begin
            if (s_data[i] !== pat(base + 32'(i * 4))) e++;
            if (s_sop[i] !== (i == 0)) e++;
            if (s_eop[i] !== (i == n - 1)) e++;
        end
        return e + ((s_data.size() != n) ? 1 : 0);
    endfunction

    task automatic start_xfer(input logic [31:0] base, input int words);
        @(posedge clk_clk);
        #1;
        clear_mon();
        @(negedge clk_clk);
        ctrl_base = base;
        ctrl_words = LEN_W'(words);
        ctrl_start = 1'b1;
        @(negedge clk_clk);
        ctrl_start = 1'b0;
        busy_after_start = ctrl_busy;
    endtask

    task automatic wait_done(input int max_cyc, output int cyc);
        cyc = -1;
        for (int i = 0; i < max_cyc; i++) begin
            if (ctrl_done) begin
                cyc = i;
                break;
            end
            @(negedge clk_clk);
        end
        repeat (3) @(negedge clk_clk);
    endtask

    task automatic test_reset();
        st_ready_set(1'b1);
        reset_reset = 1'b1;
        repeat (3) @(negedge clk_clk);
        reset_reset = 1'b0;
        n_tests++; if (bus.m_read !== 1'b0) begin n_fail++; $display("FAIL reset_m_read: got %b want 0", bus.m_read); end
        n_tests++; if (bus.m_address !== '0) begin n_fail++; $display("FAIL reset_m_address: got %h want 0", bus.m_address); end
        n_tests++; if (bus.m_burstcount !== '0) begin n_fail++; $display("FAIL reset_m_burstcount: got %0d want 0", bus.m_burstcount); end
        n_tests++; if (ctrl_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", ctrl_busy); end
        n_tests++; if (ctrl_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", ctrl_done); end
        n_tests++; if ({bus.st_valid, bus.st_sop, bus.st_eop} !== 3'b000) begin
            n_fail++; $display("FAIL reset_stream: got valid/sop/eop=%b want 000", {bus.st_valid, bus.st_sop, bus.st_eop});
        end
    endtask

    task automatic st_ready_set(input logic r);
        bus.st_ready = r;
    endtask

    task automatic check_bursts(input string name, input logic [31:0] ea[$], input int el[$]);
        int e = 0;
        if (b_addr.size() != ea.size()) e++;
        else for (int i = 0; i < ea.size(); i++) if (b_addr[i] !== ea[i] || b_len[i] != el[i]) e++;
        n_tests++;
        if (e != 0) begin
            n_fail++;
            $display("FAIL %s_bursts: got %0d bursts first %0d@%h, want %0d bursts first %0d@%h",
                     name, b_addr.size(), (b_len.size() > 0) ? b_len[0] : -1,
                     (b_addr.size() > 0) ? b_addr[0] : 32'hx, ea.size(), el[0], ea[0]);
        end
    endtask

    task automatic test_basic();
        int cyc, e;
        start_xfer(32'h1000, 200);
        n_tests++; if (busy_after_start !== 1'b1) begin n_fail++; $display("FAIL basic_busy_rise: got %b want 1", busy_after_start); end
        wait_done(2000, cyc);
        n_tests++; if (cyc < 0) begin n_fail++; $display("FAIL basic_timeout: got no done want done"); end
        check_bursts("basic", '{32'h1000, 32'h1100, 32'h1200, 32'h1300}, '{64, 64, 64, 8});
        e = stream_errs(32'h1000, 200);
        n_tests++; if (e != 0) begin n_fail++; $display("FAIL basic_stream: got %0d errors over %0d words want 0 over 200", e, s_data.size()); end
        n_tests++; if (done_cnt != 1) begin n_fail++; $display("FAIL basic_done_pulses: got %0d want 1", done_cnt); end
        n_tests++; if (ctrl_busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_fall: got %b want 0", ctrl_busy); end
    endtask

    task automatic test_stall();
        int cyc, e;
        stall_n = 5;
        start_xfer(32'h1000, 200);
        wait_done(3000, cyc);
        stall_n = 0;
        n_tests++; if (cyc < 0) begin n_fail++; $display("FAIL stall_timeout: got no done want done"); end
        check_bursts("stall", '{32'h1000, 32'h1100, 32'h1200, 32'h1300}, '{64, 64, 64, 8});
        n_tests++; if (stall_cyc != 20) begin n_fail++; $display("FAIL stall_cycles: got %0d want 20", stall_cyc); end
        n_tests++; if (hold_err != 0) begin n_fail++; $display("FAIL stall_hold: got %0d changes want 0", hold_err); end
        e = stream_errs(32'h1000, 200);
        n_tests++; if (e != 0) begin n_fail++; $display("FAIL stall_stream: got %0d errors want 0", e); end
    endtask

    task automatic test_backpressure();
        int cyc, e;
        st_ready_set(1'b0);
        start_xfer(32'h4000, 1000);
        repeat (400) @(negedge clk_clk);
        n_tests++; if (acc_words != 256) begin n_fail++; $display("FAIL bp_issued: got %0d want 256", acc_words); end
        n_tests++; if (bus.m_read !== 1'b0) begin n_fail++; $display("FAIL bp_m_read_low: got %b want 0", bus.m_read); end
        n_tests++; if (s_data.size() != 0) begin n_fail++; $display("FAIL bp_no_pop: got %0d want 0", s_data.size()); end
        st_ready_set(1'b1);
        wait_done(5000, cyc);
        n_tests++; if (cyc < 0) begin n_fail++; $display("FAIL bp_timeout: got no done want done"); end
        n_tests++; if (max_used > FIFO_DEPTH) begin n_fail++; $display("FAIL bp_credit: got %0d want <= %0d", max_used, FIFO_DEPTH); end
        e = stream_errs(32'h4000, 1000);
        n_tests++; if (e != 0) begin n_fail++; $display("FAIL bp_stream: got %0d errors over %0d words want 0 over 1000", e, s_data.size()); end
    endtask

    task automatic test_4k();
        int cyc, e;
        start_xfer(32'h0FC0, 64);
        wait_done(1000, cyc);
        n_tests++; if (cyc < 0) begin n_fail++; $display("FAIL 4k_timeout: got no done want done"); end
`ifdef BURST_4K_GUARD_EN
        check_bursts("4k", '{32'h0FC0, 32'h1000}, '{16, 48});
`else
        check_bursts("4k", '{32'h0FC0}, '{64});
`endif
        e = stream_errs(32'h0FC0, 64);
        n_tests++; if (e != 0) begin n_fail++; $display("FAIL 4k_stream: got %0d errors want 0", e); end
    endtask

    task automatic test_zero_one();
        int cyc, e;
        start_xfer(32'h0, 0);
        wait_done(10, cyc);
        n_tests++; if (cyc < 0 || cyc > 1) begin n_fail++; $display("FAIL zero_done_latency: got %0d want 0..1", cyc); end
        n_tests++; if (b_addr.size() != 0) begin n_fail++; $display("FAIL zero_no_read: got %0d bursts want 0", b_addr.size()); end
        n_tests++; if (done_cnt != 1) begin n_fail++; $display("FAIL zero_done_pulses: got %0d want 1", done_cnt); end
        start_xfer(32'h3000, 1);
        wait_done(100, cyc);
        n_tests++; if (cyc < 0) begin n_fail++; $display("FAIL one_timeout: got no done want done"); end
        check_bursts("one", '{32'h3000}, '{1});
        e = stream_errs(32'h3000, 1);
        n_tests++; if (e != 0 || s_sop[0] !== 1'b1 || s_eop[0] !== 1'b1) begin
            n_fail++; $display("FAIL one_stream: got %0d errors want single word with sop=eop=1", e);
        end
    endtask

    task automatic test_reset_mid();
        int cyc, e;
        start_xfer(32'h8000, 300);
        for (int i = 0; i < 1000 && s_data.size() < 100; i++) @(negedge clk_clk);
        n_tests++; if (s_data.size() < 100) begin n_fail++; $display("FAIL mid_progress: got %0d words want 100", s_data.size()); end
        reset_reset = 1'b1;
        @(negedge clk_clk);
        n_tests++; if ({bus.m_read, ctrl_busy, ctrl_done, bus.st_valid, bus.st_sop, bus.st_eop} !== 6'b0 ||
                       bus.m_address !== '0 || bus.m_burstcount !== '0) begin
            n_fail++; $display("FAIL mid_reset_values: got read/busy/done/valid/sop/eop=%b addr=%h bc=%0d want all 0",
                               {bus.m_read, ctrl_busy, ctrl_done, bus.st_valid, bus.st_sop, bus.st_eop}, bus.m_address, bus.m_burstcount);
        end
        @(negedge clk_clk);
        reset_reset = 1'b0;
        repeat (3) @(negedge clk_clk);
        n_tests++; if (done_cnt != 0) begin n_fail++; $display("FAIL mid_no_done: got %0d want 0", done_cnt); end
        start_xfer(32'h2000, 32);
        wait_done(500, cyc);
        n_tests++; if (cyc < 0) begin n_fail++; $display("FAIL restart_timeout: got no done want done"); end
        check_bursts("restart", '{32'h2000}, '{32});
        e = stream_errs(32'h2000, 32);
        n_tests++; if (e != 0) begin n_fail++; $display("FAIL restart_stream: got %0d errors want 0", e); end
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_basic();
        test_stall();
        test_backpressure();
        test_4k();
        test_zero_one();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end
endmodule
